// File: rtl/dado_pkg.sv
// Shared types and defaults for the dice control stage.
package dado_pkg;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    CARGA     = 2'd1,
    RODANDO   = 2'd2,
    RESULTADO = 2'd3
  } estado_t;

  localparam int CARAS_DEF     = 6;
  localparam int MAX_CARGA_DEF = 31;
  localparam int CARA_W        = 3;

endpackage

// File: rtl/control_dado.sv
// Dice control: turns button presses into counter load pulses, then spins a
// face while the throw counter drains and latches the final face.
module control_dado
  import dado_pkg::*;
#(
  parameter int CARAS     = CARAS_DEF,
  parameter int MAX_CARGA = MAX_CARGA_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clk_en_i,
  input  logic              boton_i,
  input  logic              done_i,
  output logic              iniciar_o,
  output logic              decrementar_o,
  output logic [CARA_W-1:0] cara_o,
  output logic              valido_o,
  output logic              rodando_o
);

  localparam int                CW        = $clog2(MAX_CARGA + 1);
  localparam logic [CW-1:0]     CARGA_TOP = CW'(MAX_CARGA);
  localparam logic [CARA_W-1:0] CARA_TOP  = CARA_W'(CARAS);
  localparam logic [CARA_W-1:0] CARA_UNO  = CARA_W'(1);

  estado_t           estado, estado_sig;
  logic              boton_q;
  logic              subida;
  logic [CW-1:0]     carga_cnt;
  logic [CARA_W-1:0] cara;
  logic              valido;
  logic              iniciar;

  assign subida = boton_i & ~boton_q;

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    estado_sig    = estado;
    iniciar       = 1'b0;
    decrementar_o = 1'b0;
    rodando_o     = 1'b0;
    unique case (estado)
      REPOSO: begin
        if (subida) estado_sig = CARGA;
      end
      CARGA: begin
        // Mealy pulse: one per tick while held, capped to protect the counter.
        iniciar = clk_en_i & boton_i & (carga_cnt < CARGA_TOP);
        if (!boton_i) estado_sig = RODANDO;
      end
      RODANDO: begin
        decrementar_o = 1'b1;
        rodando_o     = 1'b1;
        if (done_i) estado_sig = RESULTADO;
      end
      RESULTADO: begin
        if (subida) estado_sig = CARGA;
      end
      default: estado_sig = REPOSO;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      estado    <= REPOSO;
      boton_q   <= 1'b0;
      carga_cnt <= '0;
      cara      <= CARA_UNO;
      valido    <= 1'b0;
    end else begin
      estado  <= estado_sig;
      boton_q <= boton_i;
      valido  <= (estado_sig == RESULTADO);

      if (estado != CARGA && estado_sig == CARGA)
        carga_cnt <= '0;
      else if (iniciar)
        carga_cnt <= carga_cnt + CW'(1);

      // The face stops on the cycle done is seen, so advances equal the load.
      if (estado == RODANDO && clk_en_i && !done_i)
        cara <= (cara == CARA_TOP) ? CARA_UNO : cara + CARA_UNO;
    end
  end

  assign iniciar_o = iniciar;
  assign cara_o    = cara;
  assign valido_o  = valido;

endmodule

// File: tb/tb_control_dado.sv
// Self-checking bench for control_dado with a behavioural throw-counter model.
module tb_control_dado;

  localparam int CARAS     = 6;
  localparam int MAX_CARGA = 31;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       clk_en_i;
  logic       boton_i;
  logic       done_i;
  logic       iniciar_o;
  logic       decrementar_o;
  logic [2:0] cara_o;
  logic       valido_o;
  logic       rodando_o;

  int vectors = 0;
  int errors  = 0;
  int cnt     = 0;   // external throw counter value
  int face    = 1;   // expected current face
  int k_last  = 0;   // expected counter load of the last press

  control_dado #(.CARAS(CARAS), .MAX_CARGA(MAX_CARGA)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clk_en_i      (clk_en_i),
    .boton_i       (boton_i),
    .done_i        (done_i),
    .iniciar_o     (iniciar_o),
    .decrementar_o (decrementar_o),
    .cara_o        (cara_o),
    .valido_o      (valido_o),
    .rodando_o     (rodando_o)
  );

  always #5 clk_i = ~clk_i;

  // Throw counter: loads on iniciar, drains on gated decrementar.
  always @(posedge clk_i) begin
    if (rst_i) cnt <= 0;
    else if (iniciar_o) cnt <= cnt + 1;
    else if (decrementar_o && clk_en_i && cnt != 0) cnt <= cnt - 1;
  end
  assign done_i = (cnt == 0);

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input logic e);
    boton_i  = b;
    clk_en_i = e;
    @(negedge clk_i);
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      adv();
    end
    rst_i = 1'b0;
    face  = 1;
  endtask

  task automatic check_idle(input string tag);
    drive(1'b0, 1'($urandom_range(0, 1)));
    chk({tag, "_cara"}, 32'(cara_o), 32'(face));
    chk({tag, "_valido"}, 32'(valido_o), 0);
    chk({tag, "_dec"}, 32'(decrementar_o), 0);
    chk({tag, "_ini"}, 32'(iniciar_o), 0);
    chk({tag, "_rod"}, 32'(rodando_o), 0);
    adv();
  endtask

  // Press, hold across n ticks with random gaps, release.
  task automatic charge(input int n, input logic tick_edge, input logic tick_rel,
                        input logic valid_first);
    int issued = 0;
    int pulses = 0;
    int gap;
    drive(1'b1, tick_edge);
    chk("ini_edge", 32'(iniciar_o), 0);
    chk("val_edge", 32'(valido_o), 32'(valid_first));
    if (iniciar_o === 1'b1) pulses++;
    adv();
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        drive(1'b1, 1'b0);
        chk("ini_gap", 32'(iniciar_o), 0);
        if (iniciar_o === 1'b1) pulses++;
        adv();
      end
      drive(1'b1, 1'b1);
      chk("ini_tick", 32'(iniciar_o), 32'(issued < MAX_CARGA));
      chk("val_carga", 32'(valido_o), 0);
      if (iniciar_o === 1'b1) pulses++;
      if (issued < MAX_CARGA) issued++;
      adv();
    end
    drive(1'b0, tick_rel);
    chk("ini_release", 32'(iniciar_o), 0);
    if (iniciar_o === 1'b1) pulses++;
    adv();
    k_last = (n < MAX_CARGA) ? n : MAX_CARGA;
    chk("pulses", 32'(pulses), 32'(k_last));
  endtask

  // Drain with random ticks and button noise until done, then check result.
  task automatic spin(input int k, input logic toggle_at_done);
    int   cyc  = 0;
    logic seen = 1'b0;
    logic last;
    logic b;
    logic e;
    while (!seen && cyc < 500) begin
      last = (cnt == 0);
      b    = 1'($urandom_range(0, 1));
      e    = 1'($urandom_range(0, 1));
      if (last && toggle_at_done) begin
        b = ~boton_i;
        e = 1'b1;
      end
      drive(b, e);
      chk("rod", 32'(rodando_o), 1);
      chk("dec", 32'(decrementar_o), 1);
      chk("val_rod", 32'(valido_o), 0);
      chk("ini_rod", 32'(iniciar_o), 0);
      adv();
      cyc++;
      seen = last;
    end
    chk("spin_done", 32'(seen), 1);
    if (k == 0) chk("spin_len0", 32'(cyc), 1);
    face = ((face - 1 + k) % CARAS) + 1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)));
      chk("res_valido", 32'(valido_o), 1);
      chk("res_cara", 32'(cara_o), 32'(face));
      chk("res_dec", 32'(decrementar_o), 0);
      chk("res_rod", 32'(rodando_o), 0);
      chk("res_ini", 32'(iniciar_o), 0);
      adv();
    end
  endtask

  initial begin
    rst_i    = 1'b1;
    boton_i  = 1'b0;
    clk_en_i = 1'b0;
    adv();
    do_reset();
    check_idle("reset");
    check_idle("reposo");

    // 4 ticks, tick coincident with the press and with the release.
    charge(4, 1'b1, 1'b1, 1'b0);
    spin(k_last, 1'b0);
    chk("face_after_4", 32'(cara_o), 5);

    // Re-press from RESULTADO, 2 ticks: 5 + 2 wraps to 1.
    charge(2, 1'b0, 1'b0, 1'b1);
    spin(k_last, 1'b0);
    chk("face_wrap", 32'(cara_o), 1);

    // Saturation: 40 ticks yield 31 pulses, 1 + 31 -> 2.
    do_reset();
    charge(40, 1'b0, 1'b1, 1'b0);
    spin(k_last, 1'b0);
    chk("face_sat", 32'(cara_o), 2);

    // Press and release with no tick.
    charge(0, 1'b0, 1'b0, 1'b1);
    spin(k_last, 1'b0);

    // Button toggle and tick in the cycle done is seen.
    charge(3, 1'b1, 1'b0, 1'b1);
    spin(k_last, 1'b1);

    for (int r = 0; r < 4; r++) begin
      charge($urandom_range(0, 35), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b1);
      spin(k_last, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of RODANDO.
    charge(5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1);
      chk("pre_rst_rod", 32'(rodando_o), 1);
      adv();
    end
    do_reset();
    check_idle("mid_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/control_dado.md
Name: control_dado

Overview:
- Control stage directly upstream of the throw counter (contador_tirar) in the dice datapath; it also consumes that counter's done flag.
- Converts a debounced push-button into iniciar pulses while the button is held (charging the throw), then holds decrementar while the counter drains.
- While draining it spins a dice face on every clock-enable tick; when the counter reports done it latches and presents the final face.

Parameters:
- CARAS, 6, number of dice faces; legal range 2..7; face values run 1..CARAS.
- MAX_CARGA, 31, maximum iniciar pulses issued per button press; protects the counter's 5-bit load field from wrap-around.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- clk_en_i  input  1  one-cycle tick that paces charging and spinning; same tick feeds the counter
- boton_i  input  1  debounced button level
- done_i  input  1  counter done flag (1 = count is zero)
- iniciar_o  output  1  increment pulse to counter
- decrementar_o  output  1  decrement enable to counter; the counter gates it with its own clk_en_i
- cara_o  output  3  current face, 1..CARAS
- valido_o  output  1  cara_o is the final result
- rodando_o  output  1  high while in RODANDO

Behaviour:
- Reset (rst_i=1 sampled at posedge) from any state, mid-operation included:
  - state=REPOSO, cara_o=1, valido_o=0, carga_cnt=0, boton_q=0.
  - iniciar_o=0, decrementar_o=0, rodando_o=0.
- Edge detection: boton_q <= boton_i each cycle; subida = boton_i & ~boton_q.
- FSM states: REPOSO, CARGA, RODANDO, RESULTADO.
- REPOSO: all control outputs low. subida -> CARGA, carga_cnt<=0.
- CARGA:
  - iniciar_o = clk_en_i & boton_i & (carga_cnt < MAX_CARGA). This is a Mealy output, high in the same cycle as the tick, one cycle wide.
  - carga_cnt increments on each issued pulse.
  - boton_i=0 -> RODANDO on the next edge.
  - Ticks after MAX_CARGA pulses are ignored; state stays CARGA until release.
  - Release with zero pulses issued still goes to RODANDO.
  - valido_o cleared on entry.
- RODANDO:
  - decrementar_o=1, rodando_o=1.
  - On clk_en_i & ~done_i, cara advances: CARAS wraps to 1.
  - done_i=1 -> RESULTADO. cara does not advance in that cycle even if clk_en_i=1.
  - done_i already 1 on entry -> RESULTADO after one cycle, cara unchanged.
  - Button edges are ignored in this state.
- RESULTADO:
  - valido_o=1, cara_o held, decrementar_o=0.
  - subida -> CARGA: valido_o=0 from the next cycle, carga_cnt<=0.
- Simultaneous events:
  - subida and clk_en_i in REPOSO: transition only, no iniciar pulse that cycle.
  - Release and tick in the same CARGA cycle: no pulse, because boton_i=0 gates it.
- Net result: number of face advances equals the counter value at RODANDO entry. For a counter that starts at K, final face = ((face0-1+K) mod CARAS)+1.

Decomposition:
- Package dado_pkg:
  - typedef enum logic [1:0] estado_t {REPOSO, CARGA, RODANDO, RESULTADO}
  - localparam defaults for CARAS and MAX_CARGA
  - face width constant (3)
- No sub-module. Edge detector, carga counter and face counter stay inline.
- Top-level integration pairs control_dado with contador_tirar. It is outside this block.

Test Plan:
- Reset held 2 cycles mid-RODANDO -> next cycle cara_o=1, valido_o=0, decrementar_o=0, iniciar_o=0.
- From REPOSO, bench counter model starting at 0: raise boton_i, hold across 4 clk_en_i ticks, release -> exactly 4 single-cycle iniciar_o pulses; then RODANDO with decrementar_o=1; after 4 ticks done_i=1 -> valido_o=1, cara_o=5.
- Hold boton_i across 40 ticks -> exactly 31 iniciar_o pulses. With model at 0, 31 spins -> cara_o=2.
- Press and release with no tick in between -> 0 pulses; RODANDO sees done_i=1 -> RESULTADO within 2 cycles, cara_o unchanged, valido_o=1.
- In RESULTADO with cara_o=5, press again, 2 ticks, release -> valido_o falls the cycle after subida; final cara_o=1 (5+2 wraps).
- During RODANDO toggle boton_i and assert clk_en_i in the same cycle done_i rises -> no state change from the toggle, no extra advance, cara_o stable.
